// File: rtl/prep_eng_ctrl_pkg.sv
// Shared types and default widths for the multi-unit PREPARE engine controller.
package prep_eng_ctrl_pkg;

    typedef enum logic [2:0] {
        READY     = 3'd0,
        HANDLE_OP = 3'd1,
        SEND_META = 3'd2,
        SEND_DATA = 3'd3,
        WAIT_DONE = 3'd4
    } state_e;

    localparam int DEF_NUM_UNITS      = 2;
    localparam int DEF_DATA_BEATS     = 1;
    localparam int DEF_EARLY_ACK      = 1;
    localparam int DEF_TIMEOUT_CYCLES = 0;
    localparam int DEF_TO_W           = 16;
    localparam int DEF_CNT_W          = 32;

endpackage

// File: rtl/prep_done_tracker.sv
// Sticky per-worker completion bits; a done pulse counts in the cycle it arrives.
module prep_done_tracker
    import prep_eng_ctrl_pkg::*;
#(
    parameter int NUM_UNITS = DEF_NUM_UNITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 capture_i,
    input  logic [NUM_UNITS-1:0] done_i,
    output logic                 all_done_o
);

    logic [NUM_UNITS-1:0] done_sticky_q;
    logic [NUM_UNITS-1:0] done_sticky_d;

    // Clear wins over capture so pulses in the accept cycle are dropped.
    always_comb begin
        done_sticky_d = done_sticky_q;
        if (clear_i) begin
            done_sticky_d = '0;
        end else if (capture_i) begin
            done_sticky_d = done_sticky_q | done_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_sticky_q <= '0;
        end else begin
            done_sticky_q <= done_sticky_d;
        end
    end

    assign all_done_o = &(done_sticky_q | done_i);

endmodule

// File: rtl/prep_eng_ctrl_multi.sv
// PREPARE engine controller: starts NUM_UNITS workers, sends a multi-beat
// PREPARE-OK (early or late ack), commits VR state, times out and counts.
module prep_eng_ctrl_multi
    import prep_eng_ctrl_pkg::*;
#(
    parameter int NUM_UNITS      = DEF_NUM_UNITS,
    parameter int DATA_BEATS     = DEF_DATA_BEATS,
    parameter int EARLY_ACK      = DEF_EARLY_ACK,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int TO_W           = DEF_TO_W,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          manage_prep_msg_val,
    output logic                          prep_manage_msg_rdy,
    input  logic                          manage_prep_req_val,
    output logic                          ctrl_datap_store_info,
    input  logic                          datap_ctrl_prep_ok,
    input  logic                          datap_ctrl_log_has_space,
    output logic [NUM_UNITS-1:0]          start_units,
    input  logic [NUM_UNITS-1:0]          unit_done,
    output logic                          prep_vr_state_wr_req,
    output logic                          prep_to_udp_meta_val,
    input  logic                          to_udp_prep_meta_rdy,
    output logic                          prep_to_udp_data_val,
    output logic                          prep_to_udp_data_last,
    input  logic                          to_udp_prep_data_rdy,
    output logic [$clog2(DATA_BEATS):0]   prep_beat_idx,
    output logic                          prep_engine_rdy,
    output logic                          timeout_err,
    output logic [CNT_W-1:0]              stat_prep_cnt,
    output logic [CNT_W-1:0]              stat_commit_cnt,
    output logic [CNT_W-1:0]              stat_reject_cnt,
    output logic [CNT_W-1:0]              stat_timeout_cnt
);

    localparam int BW = $clog2(DATA_BEATS) + 1;
    localparam logic [BW-1:0]   LAST_BEAT = BW'(DATA_BEATS - 1);
    localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT_CYCLES);

    state_e            state_q, state_d;
    logic [BW-1:0]     beat_cnt_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [CNT_W-1:0]  prep_cnt_q, commit_cnt_q, reject_cnt_q, timeout_cnt_q;

    logic all_done, commit_ok, last_beat;
    logic accept, decide, beat_clr, beat_inc;

    prep_done_tracker #(.NUM_UNITS(NUM_UNITS)) u_done_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (accept),
        .capture_i  (state_q != READY),
        .done_i     (unit_done),
        .all_done_o (all_done)
    );

    assign commit_ok = datap_ctrl_prep_ok & datap_ctrl_log_has_space;
    assign last_beat = (beat_cnt_q == LAST_BEAT);

    // Every valid/ready here is a level: valid is held until its ready is seen,
    // and a transfer happens only in a cycle where both are high.
    always_comb begin
        state_d               = state_q;
        prep_manage_msg_rdy   = 1'b0;
        ctrl_datap_store_info = 1'b0;
        start_units           = '0;
        prep_to_udp_meta_val  = 1'b0;
        prep_to_udp_data_val  = 1'b0;
        prep_to_udp_data_last = 1'b0;
        prep_engine_rdy       = 1'b0;
        timeout_err           = 1'b0;
        accept                = 1'b0;
        decide                = 1'b0;
        beat_clr              = 1'b0;
        beat_inc              = 1'b0;
        case (state_q)
            READY: begin
                ctrl_datap_store_info = 1'b1;
                prep_engine_rdy       = 1'b1;
                if (manage_prep_msg_val && manage_prep_req_val) begin
                    prep_manage_msg_rdy = 1'b1;
                    start_units         = '1;
                    accept              = 1'b1;
                    state_d             = HANDLE_OP;
                end
            end
            HANDLE_OP: begin
                state_d = (EARLY_ACK != 0) ? SEND_META : WAIT_DONE;
            end
            SEND_META: begin
                prep_to_udp_meta_val = 1'b1;
                if (to_udp_prep_meta_rdy) begin
                    beat_clr = 1'b1;
                    state_d  = SEND_DATA;
                end
            end
            SEND_DATA: begin
                prep_to_udp_data_val  = 1'b1;
                prep_to_udp_data_last = last_beat;
                if (to_udp_prep_data_rdy) begin
                    beat_inc = 1'b1;
                    if (last_beat) begin
                        if (EARLY_ACK == 0) begin
                            state_d = READY;
                        end else if (all_done) begin
                            decide  = 1'b1;
                            state_d = READY;
                        end else begin
                            state_d = WAIT_DONE;
                        end
                    end
                end
            end
            WAIT_DONE: begin
                // A completion in the expiry cycle still commits.
                if (all_done) begin
                    decide = 1'b1;
                    if (EARLY_ACK == 0 && commit_ok) state_d = SEND_META;
                    else                             state_d = READY;
                end else if (TIMEOUT_CYCLES != 0 && to_cnt_q >= TO_LIMIT) begin
                    timeout_err = 1'b1;
                    state_d     = READY;
                end
            end
            default: begin
                state_d               = state_e'('x);
                prep_manage_msg_rdy   = 1'bx;
                ctrl_datap_store_info = 1'bx;
                start_units           = 'x;
                prep_to_udp_meta_val  = 1'bx;
                prep_to_udp_data_val  = 1'bx;
                prep_to_udp_data_last = 1'bx;
                prep_engine_rdy       = 1'bx;
                timeout_err           = 1'bx;
                accept                = 1'bx;
                decide                = 1'bx;
                beat_clr              = 1'bx;
                beat_inc              = 1'bx;
            end
        endcase
    end

    assign prep_vr_state_wr_req = decide & commit_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= READY;
            beat_cnt_q    <= '0;
            to_cnt_q      <= '0;
            prep_cnt_q    <= '0;
            commit_cnt_q  <= '0;
            reject_cnt_q  <= '0;
            timeout_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (beat_clr)      beat_cnt_q <= '0;
            else if (beat_inc) beat_cnt_q <= beat_cnt_q + 1'b1;
            if (accept)                                    to_cnt_q <= '0;
            else if (state_q != READY && to_cnt_q != '1)   to_cnt_q <= to_cnt_q + 1'b1;
            if (accept)                                    prep_cnt_q    <= prep_cnt_q + 1'b1;
            if (decide && commit_ok)                       commit_cnt_q  <= commit_cnt_q + 1'b1;
            if (decide && !commit_ok)                      reject_cnt_q  <= reject_cnt_q + 1'b1;
            if (timeout_err)                               timeout_cnt_q <= timeout_cnt_q + 1'b1;
        end
    end

    assign prep_beat_idx    = beat_cnt_q;
    assign stat_prep_cnt    = prep_cnt_q;
    assign stat_commit_cnt  = commit_cnt_q;
    assign stat_reject_cnt  = reject_cnt_q;
    assign stat_timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_prep_eng_ctrl_multi.sv
// Bench for prep_eng_ctrl_multi: an early-ack/3-beat instance driven from a
// vector table, and a late-ack/timeout instance driven by hand-written sequences.
module tb_prep_eng_ctrl_multi;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Input bundle bit order: {msg_val, req_val, prep_ok, has_space, done1, done0, meta_rdy, data_rdy}
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;

    logic a_msg_rdy, a_store, a_wr, a_meta, a_data, a_last, a_eng, a_terr;
    logic [1:0] a_start;
    logic [2:0] a_beat;
    logic [31:0] a_prep, a_commit, a_reject, a_tout;

    logic b_msg_rdy, b_store, b_wr, b_meta, b_data, b_last, b_eng, b_terr;
    logic [1:0] b_start;
    logic [0:0] b_beat;
    logic [31:0] b_prep, b_commit, b_reject, b_tout;

    prep_eng_ctrl_multi #(.NUM_UNITS(2), .DATA_BEATS(3), .EARLY_ACK(1), .TIMEOUT_CYCLES(0)) u_a (
        .clk(clk), .rst_n(rst_n),
        .manage_prep_msg_val(a_in[7]), .prep_manage_msg_rdy(a_msg_rdy),
        .manage_prep_req_val(a_in[6]), .ctrl_datap_store_info(a_store),
        .datap_ctrl_prep_ok(a_in[5]), .datap_ctrl_log_has_space(a_in[4]),
        .start_units(a_start), .unit_done(a_in[3:2]),
        .prep_vr_state_wr_req(a_wr),
        .prep_to_udp_meta_val(a_meta), .to_udp_prep_meta_rdy(a_in[1]),
        .prep_to_udp_data_val(a_data), .prep_to_udp_data_last(a_last),
        .to_udp_prep_data_rdy(a_in[0]), .prep_beat_idx(a_beat),
        .prep_engine_rdy(a_eng), .timeout_err(a_terr),
        .stat_prep_cnt(a_prep), .stat_commit_cnt(a_commit),
        .stat_reject_cnt(a_reject), .stat_timeout_cnt(a_tout)
    );

    prep_eng_ctrl_multi #(.NUM_UNITS(2), .DATA_BEATS(1), .EARLY_ACK(0), .TIMEOUT_CYCLES(8)) u_b (
        .clk(clk), .rst_n(rst_n),
        .manage_prep_msg_val(b_in[7]), .prep_manage_msg_rdy(b_msg_rdy),
        .manage_prep_req_val(b_in[6]), .ctrl_datap_store_info(b_store),
        .datap_ctrl_prep_ok(b_in[5]), .datap_ctrl_log_has_space(b_in[4]),
        .start_units(b_start), .unit_done(b_in[3:2]),
        .prep_vr_state_wr_req(b_wr),
        .prep_to_udp_meta_val(b_meta), .to_udp_prep_meta_rdy(b_in[1]),
        .prep_to_udp_data_val(b_data), .prep_to_udp_data_last(b_last),
        .to_udp_prep_data_rdy(b_in[0]), .prep_beat_idx(b_beat),
        .prep_engine_rdy(b_eng), .timeout_err(b_terr),
        .stat_prep_cnt(b_prep), .stat_commit_cnt(b_commit),
        .stat_reject_cnt(b_reject), .stat_timeout_cnt(b_tout)
    );

    // Expected control bit order: {msg_rdy, store_info, start[1:0], wr_req, meta_val, data_val, last, engine_rdy}
    typedef struct {
        logic [7:0] in;
        logic [8:0] ex;
        int         beat;
        int         commit;
    } vec_t;

    vec_t vecs[$];
    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [7:0] I_IDLE = 8'b0000_0000;
    localparam logic [7:0] I_ACC  = 8'b1100_0000;
    localparam logic [8:0] E_RDY  = 9'b01_00_0000_1;
    localparam logic [8:0] E_ACC  = 9'b11_11_0000_1;
    localparam logic [8:0] E_BUSY = 9'b00_00_0000_0;
    localparam logic [8:0] E_META = 9'b00_00_0100_0;
    localparam logic [8:0] E_DATA = 9'b00_00_0010_0;
    localparam logic [8:0] E_LAST = 9'b00_00_0011_0;
    localparam logic [8:0] E_LWR  = 9'b00_00_1011_0;
    localparam logic [8:0] E_WR   = 9'b00_00_1000_0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] in, input logic [8:0] ex, input int beat, input int commit);
        vec_t v;
        v.in = in; v.ex = ex; v.beat = beat; v.commit = commit;
        vecs.push_back(v);
    endtask

    task automatic drive_a(input logic [7:0] v);
        @(negedge clk);
        a_in = v;
        #1;
    endtask

    task automatic drive_b(input logic [7:0] v);
        @(negedge clk);
        b_in = v;
        #1;
    endtask

    function automatic logic [8:0] a_ctl();
        return {a_msg_rdy, a_store, a_start, a_wr, a_meta, a_data, a_last, a_eng};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Early-ack, 3 beats, data_rdy toggling, unit1 done late -> commit in WAIT_DONE
        add(I_ACC,        E_ACC,  0, 0);
        add(8'b0000_0100, E_BUSY, 0, 0);
        add(I_IDLE,       E_META, 0, 0);
        add(8'b0000_0010, E_META, 0, 0);
        add(8'b0000_0001, E_DATA, 0, 0);
        add(I_IDLE,       E_DATA, 1, 0);
        add(8'b0000_0001, E_DATA, 1, 0);
        add(I_IDLE,       E_LAST, 2, 0);
        add(8'b0000_0001, E_LAST, 2, 0);
        add(I_IDLE,       E_BUSY, 0, 0);
        add(I_IDLE,       E_BUSY, 0, 0);
        add(I_IDLE,       E_BUSY, 0, 0);
        add(I_IDLE,       E_BUSY, 0, 0);
        add(8'b0011_1000, E_WR,   0, 0);
        add(I_IDLE,       E_RDY,  0, 1);
        // Dones during SEND_META -> commit on the last data handshake
        add(I_ACC,        E_ACC,  0, 1);
        add(I_IDLE,       E_BUSY, 0, 1);
        add(8'b0000_1100, E_META, 0, 1);
        add(8'b0000_0010, E_META, 0, 1);
        add(8'b0000_0001, E_DATA, 0, 1);
        add(8'b0000_0001, E_DATA, 1, 1);
        add(8'b0011_0001, E_LWR,  2, 1);
        // Stale dones in READY and in the accept cycle must not count
        add(8'b0000_1100, E_RDY,  0, 2);
        add(8'b1100_1100, E_ACC,  0, 2);
        add(I_IDLE,       E_BUSY, 0, 2);
        add(8'b0000_0010, E_META, 0, 2);
        add(8'b0000_0001, E_DATA, 0, 2);
        add(8'b0000_0001, E_DATA, 1, 2);
        add(8'b0011_0001, E_LAST, 2, 2);
        add(8'b0011_0000, E_BUSY, 0, 2);
        add(8'b0000_1100, E_BUSY, 0, 2);
        add(I_IDLE,       E_RDY,  0, 2);

        // Reset state
        #3;
        chk("rst a ctl", a_ctl(), E_RDY);
        chk("rst a terr", a_terr, 0);
        chk("rst b meta/data/wr", {b_meta, b_data, b_wr, b_terr}, 0);
        chk("rst b rdy/store", {b_eng, b_store}, 2'b11);
        chk("rst a prep_cnt", a_prep, 0);
        chk("rst b commit_cnt", b_commit, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Late-ack reject: both dones in HANDLE_OP, no log space
        drive_b(I_ACC);
        chk("b rej accept", {b_msg_rdy, b_start}, 3'b111);
        drive_b(8'b0000_1100);
        chk("b rej handle meta", b_meta, 0);
        drive_b(8'b0010_0000);
        chk("b rej wait wr/meta", {b_wr, b_meta}, 0);
        drive_b(I_IDLE);
        chk("b rej back ready", b_eng, 1);
        chk("b reject_cnt", b_reject, 1);
        chk("b commit_cnt after reject", b_commit, 0);

        // Late-ack commit, then single-beat reply
        drive_b(I_ACC);
        drive_b(8'b0000_0100);
        chk("b com handle meta", b_meta, 0);
        drive_b(8'b0011_1000);
        chk("b com wr_req", b_wr, 1);
        drive_b(8'b0000_0010);
        chk("b com meta/data", {b_meta, b_data}, 2'b10);
        drive_b(8'b0000_0001);
        chk("b com data/last/meta/wr", {b_data, b_last, b_meta, b_wr}, 4'b1100);
        drive_b(I_IDLE);
        chk("b com back ready", b_eng, 1);
        chk("b commit_cnt", b_commit, 1);

        // Timeout: unit0 never completes; pulse exactly 8 cycles after HANDLE_OP entry
        drive_b(I_ACC);
        for (int k = 0; k <= 8; k++) begin
            drive_b(k == 0 ? 8'b0000_1000 : I_IDLE);
            chk($sformatf("b timeout_err k=%0d", k), b_terr, (k == 8) ? 1 : 0);
        end
        chk("b timeout no reply", {b_meta, b_data, b_wr}, 0);
        drive_b(I_IDLE);
        chk("b after timeout rdy/terr", {b_eng, b_terr}, 2'b10);
        chk("b timeout_cnt", b_tout, 1);
        chk("b prep_cnt", b_prep, 3);

        // Early-ack vector table
        for (int i = 0; i < vecs.size(); i++) begin
            drive_a(vecs[i].in);
            chk($sformatf("v%0d ctl", i), a_ctl(), vecs[i].ex);
            chk($sformatf("v%0d commit_cnt", i), a_commit, vecs[i].commit);
            if (vecs[i].ex[2]) chk($sformatf("v%0d beat_idx", i), a_beat, vecs[i].beat);
        end
        chk("a prep_cnt", a_prep, 3);
        chk("a reject_cnt", a_reject, 1);
        chk("a timeout_cnt", a_tout, 0);

        // Asynchronous reset during data beat 1
        drive_a(I_ACC);
        drive_a(8'b0000_1100);
        drive_a(8'b0000_0010);
        drive_a(8'b0000_0001);
        drive_a(I_IDLE);
        chk("a pre-reset beat1", {a_data, a_beat}, {1'b1, 3'd1});
        rst_n = 1'b0;
        #1;
        chk("a in reset ctl", a_ctl(), E_RDY);
        chk("a in reset counters", a_prep | a_commit | a_reject, 0);
        chk("b in reset counters", b_prep | b_commit | b_tout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_a(I_ACC);
        chk("a post-reset accept", a_ctl(), E_ACC);
        drive_a(8'b0000_1100);
        drive_a(8'b0000_0010);
        chk("a post-reset meta", a_meta, 1);
        drive_a(8'b0000_0001);
        drive_a(8'b0000_0001);
        drive_a(8'b0011_0001);
        chk("a post-reset last wr", a_ctl(), E_LWR);
        drive_a(I_IDLE);
        chk("a post-reset ready", a_eng, 1);
        chk("a post-reset commit_cnt", a_commit, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prep_eng_ctrl_multi.md
Name: prep_eng_ctrl_multi

Overview:
- Parametrised successor to the VR PREPARE engine controller.
- Sits between the manage/dispatch stage and the UDP TX path.
- Accepts one PREPARE at a time, starts NUM_UNITS downstream workers (log writer, log cleaner, mirror, ...) and tracks their completion pulses.
- Sends a multi-beat PREPARE-OK, either before durability (early-ack) or after it (late-ack). Commits VR state, enforces a completion timeout and keeps statistics counters.

Parameters:
- NUM_UNITS, 2, number of downstream workers started per PREPARE (>=1).
- DATA_BEATS, 1, beats in the PREPARE-OK payload (>=1).
- EARLY_ACK, 1, 1 = reply before workers finish; 0 = reply only after all finish and commit is allowed.
- TIMEOUT_CYCLES, 0, cycles from HANDLE_OP entry before abort; 0 disables the timeout.
- TO_W, 16, timeout counter width.
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- manage_prep_msg_val  in  1  metadata valid.
- prep_manage_msg_rdy  out  1  metadata accept.
- manage_prep_req_val  in  1  request data present.
- ctrl_datap_store_info  out  1  datapath captures request info.
- datap_ctrl_prep_ok  in  1  view/op-number check passed.
- datap_ctrl_log_has_space  in  1  log has room.
- start_units  out  NUM_UNITS  one-cycle start pulse per worker.
- unit_done  in  NUM_UNITS  one-cycle done pulse per worker.
- prep_vr_state_wr_req  out  1  one-cycle VR state commit.
- prep_to_udp_meta_val  out  1  reply metadata valid.
- to_udp_prep_meta_rdy  in  1  reply metadata ready.
- prep_to_udp_data_val  out  1  reply data valid.
- prep_to_udp_data_last  out  1  final reply beat.
- to_udp_prep_data_rdy  in  1  reply data ready.
- prep_beat_idx  out  $clog2(DATA_BEATS)+1  current beat index for the datapath mux.
- prep_engine_rdy  out  1  high in READY.
- timeout_err  out  1  one-cycle pulse on abort.
- stat_prep_cnt / stat_commit_cnt / stat_reject_cnt / stat_timeout_cnt  out  CNT_W each  accepted / committed / rejected / timed-out PREPAREs.

Behaviour:
- Reset (rst_n low, asynchronous): state READY; done_sticky, beat_cnt, to_cnt and all stat counters = 0.
- While in reset, every valid/pulse output is 0. ctrl_datap_store_info and prep_engine_rdy are 1 because state is READY.
- Control outputs are combinational from the state and inputs. Counters and sticky bits are registered.
- all_done = &(done_sticky | unit_done). A done pulse is usable in the cycle it arrives.
- commit_ok = datap_ctrl_prep_ok & datap_ctrl_log_has_space, sampled when the commit decision is made.
- Commit outcomes:
  - Commit: prep_vr_state_wr_req=1 for one cycle; stat_commit_cnt++.
  - Reject (no commit): stat_reject_cnt++.
- READY:
  - ctrl_datap_store_info=1.
  - If msg_val & req_val: msg_rdy=1, start_units='1, done_sticky<=0, to_cnt<=0, stat_prep_cnt++, go to HANDLE_OP.
  - unit_done pulses arriving in READY are ignored, including in the accept cycle.
- HANDLE_OP: one cycle; done_sticky accumulates. Next state is SEND_META if EARLY_ACK=1, else WAIT_DONE.
- SEND_META: meta_val=1. On meta_rdy: beat_cnt<=0, go to SEND_DATA.
- SEND_DATA:
  - data_val=1; last=(beat_cnt==DATA_BEATS-1); beat_cnt increments on each data_rdy.
  - On data_rdy & last:
    - EARLY_ACK=1 with all_done: commit decision in the same cycle, go to READY.
    - EARLY_ACK=1 without all_done: go to WAIT_DONE.
    - EARLY_ACK=0: go to READY (commit already done).
- WAIT_DONE: on all_done:
  - EARLY_ACK=1: commit decision, go to READY.
  - EARLY_ACK=0 and commit_ok: commit, go to SEND_META.
  - EARLY_ACK=0 and !commit_ok: reject, no reply sent, go to READY.
- Timeout:
  - to_cnt increments every cycle outside READY and saturates.
  - Checked only in WAIT_DONE. If TIMEOUT_CYCLES!=0, to_cnt>=TIMEOUT_CYCLES and !all_done: timeout_err=1, stat_timeout_cnt++, no commit, go to READY.
  - all_done in the same cycle as expiry wins.
- Handshakes: val is held until rdy. meta and data are never asserted in the same cycle. beat_cnt does not advance without rdy.
- Stat counters wrap modulo 2^CNT_W.
- Illegal state encoding drives X on outputs and X on next state (simulation only).

Decomposition:
- Package prep_eng_ctrl_pkg holds the state_e enum (READY, HANDLE_OP, SEND_META, SEND_DATA, WAIT_DONE) and the default width constants.
- Sub-module prep_done_tracker holds the NUM_UNITS sticky done bits with clear input and all_done output. It is reusable by the commit engine.

Test Plan:
- EARLY_ACK=1, NUM_UNITS=2, DATA_BEATS=1; dones arrive during SEND_META; prep_ok=1, has_space=1 -> meta then one last beat. wr_req pulses on the data handshake cycle. commit_cnt=1.
- EARLY_ACK=1, DATA_BEATS=3, data_rdy toggling 1,0,1,0,1 -> beat_idx 0,1,1,2,2; last only on beat 2; unit1 done 5 cycles later -> wr_req in WAIT_DONE.
- EARLY_ACK=0, has_space=0, both dones in HANDLE_OP -> no meta_val, no wr_req, reject_cnt=1, back to READY in 3 cycles.
- EARLY_ACK=0, TIMEOUT_CYCLES=8, unit0 never done -> timeout_err once, 8 cycles after HANDLE_OP entry; timeout_cnt=1; no reply; prep_engine_rdy=1 the next cycle.
- unit_done pulse in READY, then accept -> the stale pulse is not counted; engine waits for fresh dones.
- rst_n low during SEND_DATA beat 1 -> all vals drop immediately; after release: READY, counters 0, next PREPARE completes normally.
